// File: rtl/meas_delay_sched_pkg.sv
// rtl/meas_delay_sched_pkg.sv - shared types and width helpers for the delay-meter scheduler
package meas_delay_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_ARM,
    ST_WAIT,
    ST_REPORT
  } state_t;

  // Accumulator holds 2^log2_navg full-scale codes without wrapping.
  function automatic int acc_w(input int dw, input int log2_navg);
    return dw + log2_navg;
  endfunction

  // One timer serves both the settle count and the per-sample timeout.
  function automatic int tmr_w(input int tmo_cyc, input int settle);
    return $clog2(((tmo_cyc > settle) ? tmo_cyc : settle) + 1);
  endfunction

endpackage

// File: rtl/meas_delay_sched_rr_arbiter.sv
// rtl/meas_delay_sched_rr_arbiter.sv - combinational round-robin pick of first requester at/after ptr
module rr_arbiter #(
  parameter int NCH = 4
) (
  input  logic [NCH-1:0]         req,
  input  logic [$clog2(NCH)-1:0] ptr,
  output logic [$clog2(NCH)-1:0] grant,
  output logic                   any_req
);
  localparam int PW = $clog2(NCH);
  localparam logic [PW:0] NCH_W = (PW+1)'(NCH);

  logic [NCH-1:0] rot;
  logic [PW-1:0]  off;
  logic [PW:0]    sum;

  // Rotate so bit 0 is the pointer channel, take the lowest set offset, rotate back.
  always_comb begin
    rot = NCH'({req, req} >> ptr);
    off = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (rot[i]) off = PW'(i);
    end
    sum     = {1'b0, ptr} + {1'b0, off};
    grant   = (sum >= NCH_W) ? PW'(sum - NCH_W) : PW'(sum);
    any_req = |req;
  end

endmodule

// File: rtl/meas_delay_sched.sv
// rtl/meas_delay_sched.sv - shares one delay meter among NCH channels; optional MEAS_DELAY_SCHED_MINMAX_EN
module meas_delay_sched
  import meas_delay_sched_pkg::*;
#(
  parameter int NCH       = 4,
  parameter int DW        = 16,
  parameter int LOG2_NAVG = 2,
  parameter int SETTLE    = 3,
  parameter int TMO_CYC   = 1000
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [NCH-1:0]         req,
  output logic [$clog2(NCH)-1:0] sel,
  output logic                   meas_start,
  input  logic                   meas_done,
  input  logic [DW-1:0]          meas_val,
  output logic                   busy,
  output logic                   res_valid,
  output logic [$clog2(NCH)-1:0] res_ch,
  output logic [DW-1:0]          res_val,
  output logic                   res_err
`ifdef MEAS_DELAY_SCHED_MINMAX_EN
  ,
  output logic [DW-1:0]          res_min,
  output logic [DW-1:0]          res_max
`endif
);
  localparam int PW = $clog2(NCH);
  localparam int AW = acc_w(DW, LOG2_NAVG);
  localparam int TW = tmr_w(TMO_CYC, SETTLE);
  localparam int CW = LOG2_NAVG + 1;

  state_t         state, state_nx;
  logic [PW-1:0]  ptr, gnt;
  logic           any_req;
  logic [AW-1:0]  acc, acc_sum;
  logic [CW-1:0]  cnt;
  logic [TW-1:0]  tmr;
  logic           last_smp, tmo_hit, settle_done;

  rr_arbiter #(.NCH(NCH)) u_arb (
    .req     (req),
    .ptr     (ptr),
    .grant   (gnt),
    .any_req (any_req)
  );

  assign acc_sum     = acc + AW'(meas_val);
  assign last_smp    = (cnt == CW'((1 << LOG2_NAVG) - 1));
  // In WAIT the timer holds cycles elapsed since meas_start.
  assign tmo_hit     = (tmr == TW'(TMO_CYC - 1));
  assign settle_done = (tmr == TW'(SETTLE - 1));

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_nx;
  end

  // Next state and state-decoded strobes; a done coinciding with timeout is taken as a sample.
  always_comb begin
    state_nx   = state;
    meas_start = 1'b0;
    busy       = 1'b1;
    res_valid  = 1'b0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (any_req) state_nx = ST_SETTLE;
      end
      ST_SETTLE: if (settle_done) state_nx = ST_ARM;
      ST_ARM: begin
        meas_start = 1'b1;
        state_nx   = ST_WAIT;
      end
      ST_WAIT: begin
        if (meas_done)    state_nx = last_smp ? ST_REPORT : ST_ARM;
        else if (tmo_hit) state_nx = ST_REPORT;
      end
      ST_REPORT: begin
        res_valid = 1'b1;
        state_nx  = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Datapath: grant capture, timers, accumulation, and result registers loaded on entry to REPORT.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr     <= '0;
      sel     <= '0;
      acc     <= '0;
      cnt     <= '0;
      tmr     <= '0;
      res_ch  <= '0;
      res_val <= '0;
      res_err <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          tmr <= '0;
          if (any_req) sel <= gnt;
        end
        ST_SETTLE: tmr <= tmr + 1'b1;
        ST_ARM:    tmr <= TW'(1);
        ST_WAIT: begin
          tmr <= tmr + 1'b1;
          if (meas_done) begin
            acc <= acc_sum;
            cnt <= cnt + 1'b1;
            if (last_smp) begin
              res_ch  <= sel;
              res_val <= DW'(acc_sum >> LOG2_NAVG);
              res_err <= 1'b0;
            end
          end else if (tmo_hit) begin
            res_ch  <= sel;
            res_val <= '0;
            res_err <= 1'b1;
          end
        end
        ST_REPORT: begin
          ptr <= (sel == PW'(NCH - 1)) ? '0 : sel + 1'b1;
          acc <= '0;
          cnt <= '0;
        end
        default: ;
      endcase
    end
  end

`ifdef MEAS_DELAY_SCHED_MINMAX_EN
  logic [DW-1:0] run_min, run_max, nx_min, nx_max;

  assign nx_min = (meas_val < run_min) ? meas_val : run_min;
  assign nx_max = (meas_val > run_max) ? meas_val : run_max;

  // Per-request extremes, snapshotted alongside the average (partial set on timeout).
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      run_min <= '1;
      run_max <= '0;
      res_min <= '0;
      res_max <= '0;
    end else if (state == ST_IDLE && any_req) begin
      run_min <= '1;
      run_max <= '0;
    end else if (state == ST_WAIT) begin
      if (meas_done) begin
        run_min <= nx_min;
        run_max <= nx_max;
        if (last_smp) begin
          res_min <= nx_min;
          res_max <= nx_max;
        end
      end else if (tmo_hit) begin
        res_min <= run_min;
        res_max <= run_max;
      end
    end
  end
`endif

endmodule

// File: tb/tb_meas_delay_sched.sv
// tb/tb_meas_delay_sched.sv - directed self-checking bench for meas_delay_sched
module tb_meas_delay_sched;

  logic        clk = 1'b0;
  logic        rstn;
  logic [3:0]  req;
  logic [1:0]  sel;
  logic        meas_start;
  logic        meas_done;
  logic [15:0] meas_val;
  logic        busy;
  logic        res_valid;
  logic [1:0]  res_ch;
  logic [15:0] res_val;
  logic        res_err;
`ifdef MEAS_DELAY_SCHED_MINMAX_EN
  logic [15:0] res_min, res_max;
`endif

  meas_delay_sched #(.NCH(4), .DW(16), .LOG2_NAVG(2), .SETTLE(3), .TMO_CYC(50)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req        (req),
    .sel        (sel),
    .meas_start (meas_start),
    .meas_done  (meas_done),
    .meas_val   (meas_val),
    .busy       (busy),
    .res_valid  (res_valid),
    .res_ch     (res_ch),
    .res_val    (res_val),
    .res_err    (res_err)
`ifdef MEAS_DELAY_SCHED_MINMAX_EN
    ,
    .res_min    (res_min),
    .res_max    (res_max)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int ch;
    int val;
    int err;
    int sel;
    int lat_start;
    int lat_busy;
  } res_t;

  int   n_chk = 0;
  int   n_bad = 0;
  res_t rq[$];
  int   r0 = 0;
  int   cyc = 0;
  int   n_start = 0;
  int   last_start = 0;
  int   busy_rise = 0;
  bit   busy_q = 1'b0;
  bit   gap_en = 1'b0;
  int   idle_run = 0;
  int   max_gap = 0;
  int   mq[$];
  bit   meter_on = 1'b1;
  int   dly = 1;
  bit   stray = 1'b0;
  int   pend = 0;
  logic [15:0] pv = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic res_t rr(input int i);
    res_t z = '{default: -1};
    if (r0 + i < rq.size()) return rq[r0 + i];
    return z;
  endfunction

  // Meter model: answers each start after dly cycles; stray injects an unsolicited done.
  initial begin
    meas_done = 1'b0;
    meas_val  = '0;
    forever begin
      @(posedge clk); #1;
      meas_done = 1'b0;
      if (!rstn) pend = 0;
      if (stray) begin
        meas_done = 1'b1;
        meas_val  = 16'd5000;
        stray     = 1'b0;
      end else if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          meas_done = 1'b1;
          meas_val  = pv;
        end
      end
      if (meas_start && meter_on && rstn) begin
        pend = dly;
        pv   = (mq.size() > 0) ? 16'(mq.pop_front()) : 16'(1000 + 16 * int'(sel));
      end
    end
  end

  // Monitor on the falling edge.
  initial forever begin
    res_t r;
    @(negedge clk);
    cyc++;
    if (meas_start) begin
      n_start++;
      last_start = cyc;
    end
    if (busy && !busy_q) busy_rise = cyc;
    busy_q = busy;
    if (!gap_en) begin
      max_gap  = 0;
      idle_run = 0;
    end else if (busy) begin
      if (idle_run > max_gap) max_gap = idle_run;
      idle_run = 0;
    end else begin
      idle_run++;
    end
    if (res_valid) begin
      r.ch        = int'(res_ch);
      r.val       = int'(res_val);
      r.err       = int'(res_err);
      r.sel       = int'(sel);
      r.lat_start = cyc - last_start;
      r.lat_busy  = cyc - busy_rise;
      rq.push_back(r);
    end
  end

  task automatic wait_res(input int n, input int budget);
    int k = 0;
    while (rq.size() - r0 < n && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    chk("res_count", rq.size() - r0, n);
  endtask

  task automatic end_req(input int n);
    req = '0;
    repeat (20) begin @(posedge clk); #1; end
    chk("no_extra_res", rq.size() - r0, n);
    chk("idle_busy", busy, 0);
  endtask

  task automatic wait_busy();
    int k = 0;
    while (!busy && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk("busy_seen", busy, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int s0;
    rstn = 1'b0;
    req  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sel", sel, 0);
    chk("rst_start", meas_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", res_valid, 0);
    chk("rst_ch", res_ch, 0);
    chk("rst_val", res_val, 0);
    chk("rst_err", res_err, 0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // Round robin with all four requesting.
    r0 = rq.size();
    gap_en = 1'b1;
    req = 4'b1111;
    wait_res(8, 400);
    end_req(8);
    for (int i = 0; i < 8; i++) begin
      chk("rr_ch", rr(i).ch, i % 4);
      chk("rr_val", rr(i).val, 1000 + 16 * (i % 4));
    end
    chk("rr_gap", max_gap, 1);
    gap_en = 1'b0;

    // Single request, req dropped once granted.
    r0 = rq.size();
    s0 = n_start;
    mq = '{100, 102, 104, 106};
    req = 4'b0010;
    wait_busy();
    req = '0;
    wait_res(1, 200);
    end_req(1);
    chk("one_ch", rr(0).ch, 1);
    chk("one_sel", rr(0).sel, 1);
    chk("one_val", rr(0).val, 103);
    chk("one_err", rr(0).err, 0);
    chk("one_starts", n_start - s0, 4);
    chk("one_lat", rr(0).lat_busy, 11);

    // Timeout on ch2, then ch3 served.
    r0 = rq.size();
    meter_on = 1'b0;
    req = 4'b1100;
    wait_res(1, 200);
    meter_on = 1'b1;
    wait_res(2, 200);
    end_req(2);
    chk("tmo_ch", rr(0).ch, 2);
    chk("tmo_err", rr(0).err, 1);
    chk("tmo_val", rr(0).val, 0);
    chk("tmo_lat", rr(0).lat_start, 50);
    chk("next_ch", rr(1).ch, 3);
    chk("next_err", rr(1).err, 0);
    chk("next_val", rr(1).val, 1048);

    // Done lands on the last timeout cycle for every sample.
    r0 = rq.size();
    dly = 49;
    mq = '{7, 7, 7, 7};
    req = 4'b0001;
    wait_res(1, 400);
    end_req(1);
    dly = 1;
    chk("coin_ch", rr(0).ch, 0);
    chk("coin_err", rr(0).err, 0);
    chk("coin_val", rr(0).val, 7);
    chk("coin_lat", rr(0).lat_start, 50);

    // Stray done during SETTLE.
    r0 = rq.size();
    s0 = n_start;
    mq = '{10, 20, 30, 40};
    req = 4'b0001;
    wait_busy();
    stray = 1'b1;
    wait_res(1, 200);
    end_req(1);
    chk("stray_val", rr(0).val, 25);
    chk("stray_starts", n_start - s0, 4);

    // Full-scale and truncation.
    r0 = rq.size();
    mq = '{65535, 65535, 65535, 65535};
    req = 4'b1000;
    wait_res(1, 200);
    end_req(1);
    chk("full_ch", rr(0).ch, 3);
    chk("full_val", rr(0).val, 65535);
    r0 = rq.size();
    mq = '{1, 1, 1, 2};
    req = 4'b0100;
    wait_res(1, 200);
    end_req(1);
    chk("trunc_ch", rr(0).ch, 2);
    chk("trunc_val", rr(0).val, 1);

    // Async reset in WAIT; pointer was 3 beforehand.
    r0 = rq.size();
    s0 = n_start;
    dly = 20;
    req = 4'b0010;
    for (int k = 0; k < 30 && n_start == s0; k++) begin @(posedge clk); #1; end
    chk("arst_started", n_start - s0, 1);
    repeat (5) @(posedge clk);
    #3;
    rstn = 1'b0;
    req = '0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_start", meas_start, 0);
    chk("arst_valid", res_valid, 0);
    chk("arst_sel", sel, 0);
    chk("arst_ch", res_ch, 0);
    chk("arst_val", res_val, 0);
    chk("arst_err", res_err, 0);
    #27;
    rstn = 1'b1;
    dly = 1;
    repeat (3) begin @(posedge clk); #1; end
    chk("arst_no_res", rq.size() - r0, 0);
    req = 4'b1010;
    wait_res(1, 200);
    end_req(1);
    chk("arst_next_ch", rr(0).ch, 1);
    chk("arst_next_val", rr(0).val, 1016);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/meas_delay_sched.md
Name: meas_delay_sched

Overview:
- Time-multiplexes one shared delay meter among NCH requesting channels.
- Per request: selects the channel's signal pair, waits for mux settling, then arms the meter 2^LOG2_NAVG times.
- Accumulates the returned delay codes and reports a truncated average per channel.
- Sits between the measurement-control logic and the single meter instance in the characterization/calibration path.

Parameters:
- NCH, 4: number of requesting channels (2..16).
- DW, 16: width of the meter's delay code (unsigned).
- LOG2_NAVG, 2: log2 of samples averaged per request (0..6).
- SETTLE, 3: cycles held in SETTLE after sel changes, before first start (>=1).
- TMO_CYC, 1000: max cycles waiting for meas_done per sample before abort.

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- req  in  NCH  per-channel level request; a channel stays eligible while high.
- sel  out  $clog2(NCH)  channel select to the meter's input mux.
- meas_start  out  1  one-cycle pulse arming the meter.
- meas_done  in  1  one-cycle pulse from the meter: sample ready.
- meas_val  in  DW  delay code, valid when meas_done=1.
- busy  out  1  high in any state except IDLE.
- res_valid  out  1  one-cycle result strobe.
- res_ch  out  $clog2(NCH)  channel of the result.
- res_val  out  DW  averaged delay code.
- res_err  out  1  result aborted by timeout.

Behaviour:
- Reset (rstn low, async): state IDLE; sel=0, meas_start=0, busy=0, res_valid=0, res_ch=0, res_val=0, res_err=0; accumulator, sample counter and timer cleared; round-robin pointer = channel 0.
- Reset mid-operation aborts silently; no result is emitted.
- State machine:
  - IDLE: if any req bit is high, grant the first requester at or after the pointer (round-robin), then go to SETTLE. sel updates in that same transition.
  - SETTLE: count SETTLE cycles, then go to ARM.
  - ARM: assert meas_start for exactly one cycle, clear the timer, go to WAIT.
  - WAIT: timer increments each cycle.
    - On meas_done: add the zero-extended meas_val to the accumulator (width DW+LOG2_NAVG). If this was the last sample go to REPORT, otherwise go to ARM.
    - If timer reaches TMO_CYC-1 without meas_done: set the error flag, go to REPORT.
    - If meas_done and timeout coincide, meas_done wins.
  - REPORT: one cycle.
    - res_valid=1; res_ch=granted channel; res_val = acc >> LOG2_NAVG (truncating); res_err = error flag.
    - On error, res_val = 0.
    - Pointer moves to granted+1, wrapping modulo NCH; clear acc, counter and flag; go to IDLE.
- res_ch, res_val and res_err hold their values between strobes.
- meas_done seen outside WAIT is ignored and does not count as a sample.
- If a req drops after grant, the sequence still completes and reports.
- Minimum latency from IDLE grant to res_valid, with meas_done arriving the cycle after start: 1 + SETTLE + 2·2^LOG2_NAVG cycles.
- No back-to-back grants: at least one IDLE cycle between results.
- The accumulator never overflows: width is DW+LOG2_NAVG.

Optional Feature:
- MEAS_DELAY_SCHED_MINMAX_EN defined:
  - Adds outputs res_min and res_max (each DW wide), holding the smallest and largest sample of the request.
  - Both are valid with res_valid. They are reset to all-ones and 0 respectively at the start of each request.
  - On timeout they report the samples collected so far.
- Not defined: these ports and registers are absent; behaviour is otherwise identical.

Decomposition:
- Package meas_delay_sched_pkg:
  - state enum (IDLE, SETTLE, ARM, WAIT, REPORT).
  - width helper constant for the accumulator.
  - TMO timer width derived from TMO_CYC.
- One sub-module, rr_arbiter:
  - Inputs: NCH-bit req, pointer.
  - Outputs: grant index and any_req (combinational).
  - Reusable for other shared meters.

Test Plan:
- Single request: NCH=4, LOG2_NAVG=2, req=0010, meter returns 100, 102, 104, 106. Expect sel=1, four meas_start pulses, one res_valid with res_ch=1, res_val=103, res_err=0.
- Round-robin fairness: req=1111 held through 8 results. Expect res_ch sequence 0,1,2,3,0,1,2,3 and busy never low for more than 1 cycle between results.
- Timeout: TMO_CYC=50, meter never responds. Expect res_valid exactly 50 cycles after meas_start, res_err=1, res_val=0; next requester is then served.
- Coincidence and stray pulses:
  - meas_done on the final timeout cycle: result accepted, res_err=0.
  - meas_done pulsed during SETTLE: ignored, still 4 starts.
- Truncation/width: DW=16, all samples 0xFFFF. Expect res_val=0xFFFF, no overflow. Samples 1,1,1,2 give res_val=1.
- Async reset mid-WAIT: rstn low for 3 cycles, unsynchronized to clk. Expect all outputs 0 immediately, no res_valid, and the next grant starts from channel 0.
